led_frame_buffer: RTL
=====================

// Module: led_frame_buffer
// PURPOSE
// - Double-buffered 6x6 frame store. It drives the 36-bit img bus of the multiplexed LED matrix driver.
// - Producer logic (animations, game logic, UART loader) draws into a hidden back buffer through a
//   valid/ready write port, then requests a swap.
// - The swap commits only on a frame_tick, so the displayed image never tears mid-draw.
// - A row-serial clear engine wipes the back buffer on request.
// PARAMETERS
// - DIM_X  6  columns per row; pixel (x,y) maps to img[DIM_X*y + x]
// - DIM_Y  6  rows; row y occupies img[DIM_X*y+DIM_X-1 : DIM_X*y]
// PORTS
// - clk        in   1  system clock; single clock domain
// - rst        in   1  synchronous, active-high reset
// - wr_valid   in   1  write request
// - wr_ready   out  1  write accepted when wr_valid & wr_ready at posedge clk
// - wr_op      in   2  00 set pixel, 01 clear pixel, 10 toggle pixel, 11 write whole row
// - wr_x       in   3  column for pixel ops; ignored for op 11
// - wr_y       in   3  row for all ops
// - wr_data    in   6  row data for op 11; bit x -> column x; ignored otherwise
// - clr_req    in   1  1-cycle pulse: clear back buffer
// - swap_req   in   1  1-cycle pulse: make back buffer visible at next frame_tick
// - frame_tick in   1  1-cycle pulse at display frame boundary
// - swap_ack   out  1  1-cycle pulse in the cycle the swap commits
// - busy       out  1  high while state != IDLE
// - oob        out  1  1-cycle pulse: an accepted write had x>=DIM_X or y>=DIM_Y
// - img        out 36  registered copy of the front buffer, to the matrix driver
// BEHAVIOUR
// - Storage: two 36-bit buffers, buf0 and buf1, plus front_sel. The back buffer is !front_sel.
// - Reset: both buffers = 0, front_sel = 0, img = 0, state = IDLE; swap_ack, busy, oob = 0.
// - FSM states: IDLE, CLEAR, SWAP_PEND.
// - IDLE: request priority each cycle is clr_req > swap_req > write.
//   - clr_req -> CLEAR, with row counter = 0.
//   - else swap_req -> SWAP_PEND.
//   - A request arriving outside IDLE is dropped silently.
// - wr_ready = (state==IDLE) & ~clr_req & ~swap_req. This is combinational.
// - An accepted write modifies the back buffer at the same posedge; it is readable next cycle.
// - Out-of-range writes: accepted (handshake completes), buffers unchanged, oob pulses the next cycle.
// - CLEAR: zero one back-buffer row per cycle, rows 0..DIM_Y-1, so DIM_Y cycles total.
//   - After row DIM_Y-1, go to IDLE. The front buffer and img are untouched.
// - SWAP_PEND: wait for frame_tick.
//   - On the tick cycle: front_sel flips and swap_ack=1, then go to IDLE.
//   - If frame_tick is already high in the cycle after swap_req, the swap commits in that cycle.
//   - Minimum swap latency is 1 cycle after swap_req; there is no upper bound, since it is tick-paced.
// - img <= front buffer every cycle. img shows the new frame 1 cycle after swap_ack.
// - A swap never copies data. The new back buffer holds the frame that was displayed previously.
// - frame_tick in IDLE or CLEAR has no effect.
// - rst asserted mid-CLEAR or in SWAP_PEND aborts the operation and reinstates all reset values.
// - Toggle on the same pixel in consecutive cycles is applied twice, restoring the original value.
// CONFIGURATION
// - FB_AUTO_CLEAR_EN defined:
//   - After each swap commit (swap_ack cycle), the FSM enters CLEAR on the new back buffer
//     instead of IDLE.
//   - busy stays high for DIM_Y more cycles.
//   - Net effect: each swap is followed by a blank canvas.
// - FB_AUTO_CLEAR_EN undefined:
//   - Swap returns to IDLE.
//   - The back buffer retains the previously displayed frame, for incremental redraw.
// TESTING
// - Reset, then write op 00 at (x=2,y=3), swap_req, frame_tick 5 cycles later.
//   -> swap_ack on the tick cycle; img == 36'h1 << 20 the next cycle.
// - Write op 11 with y=5, data=6'b101011, then swap + tick.
//   -> img[35:30] == 6'b101011 and all other bits 0.
// - Write with x=6,y=0 (out of range). -> wr_ready=1, oob pulses once, buffers unchanged after swap.
// - clr_req and swap_req in the same IDLE cycle.
//   -> CLEAR for exactly 6 busy cycles, swap ignored, wr_ready=0 throughout.
// - swap_req with no tick for 100 cycles.
//   -> busy=1, img unchanged, wr_ready=0; the tick then commits the swap.
//   -> Assert rst mid-CLEAR: img=0, busy=0 on the next cycle.
// - With FB_AUTO_CLEAR_EN, fill the back buffer with all ones, then swap.
//   -> img all ones; busy high 6 cycles after swap_ack; a second swap makes img = 0.

Source files
------------

// File: rtl/led_frame_buffer.sv
// Double-buffered DIM_X x DIM_Y LED frame store with tick-paced swap and row-serial back-buffer clear.
// Optional: define FB_AUTO_CLEAR_EN to clear the new back buffer automatically after every swap.

module led_fb_row #(
   parameter int W = 6
) (
   input  logic [W-1:0] cur,
   input  logic         wr_en,
   input  logic [1:0]   op,
   input  logic [2:0]   x,
   input  logic [W-1:0] data,
   input  logic         clr,
   output logic [W-1:0] nxt
);
   logic [W-1:0] mask;

   assign mask = W'(1) << x;

   always_comb begin
      nxt = cur;
      if (clr) begin
         nxt = '0;
      end else if (wr_en) begin
         case (op)
            2'b00:   nxt = cur | mask;
            2'b01:   nxt = cur & ~mask;
            2'b10:   nxt = cur ^ mask;
            default: nxt = data;
         endcase
      end
   end
endmodule

module led_frame_buffer #(
   parameter int DIM_X = 6,
   parameter int DIM_Y = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [1:0]             wr_op,
   input  logic [2:0]             wr_x,
   input  logic [2:0]             wr_y,
   input  logic [DIM_X-1:0]       wr_data,
   input  logic                   clr_req,
   input  logic                   swap_req,
   input  logic                   frame_tick,
   output logic                   swap_ack,
   output logic                   busy,
   output logic                   oob,
   output logic [DIM_X*DIM_Y-1:0] img
);
   localparam int RW = (DIM_Y > 1) ? $clog2(DIM_Y) : 1;

   typedef enum logic [1:0] {IDLE, CLEAR, SWAP_PEND} state_t;
   typedef logic [DIM_Y-1:0][DIM_X-1:0] frame_t;

   state_t          state, state_nxt;
   logic [RW-1:0]   row_cnt, row_nxt;
   logic            front_sel;
   frame_t          buf0, buf1, front, back, back_nxt;
   logic            wr_fire, in_range, clr_active, commit;

   assign front    = front_sel ? buf1 : buf0;
   assign back     = front_sel ? buf0 : buf1;
   assign wr_ready = (state == IDLE) & ~clr_req & ~swap_req;
   assign wr_fire  = wr_valid & wr_ready;
   // Row writes ignore x, so only y bounds them.
   assign in_range = (32'(wr_y) < DIM_Y) && ((wr_op == 2'b11) || (32'(wr_x) < DIM_X));
   assign swap_ack = commit;
   assign busy     = (state != IDLE);

   for (genvar y = 0; y < DIM_Y; y++) begin : g_row
      led_fb_row #(.W(DIM_X)) u_row (
         .cur   (back[y]),
         .wr_en (wr_fire & in_range & (32'(wr_y) == y)),
         .op    (wr_op),
         .x     (wr_x),
         .data  (wr_data),
         .clr   (clr_active & (32'(row_cnt) == y)),
         .nxt   (back_nxt[y])
      );
   end

   always_comb begin
      state_nxt  = state;
      row_nxt    = row_cnt;
      clr_active = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               row_nxt   = '0;
            end else if (swap_req) begin
               state_nxt = SWAP_PEND;
            end
         end
         CLEAR: begin
            clr_active = 1'b1;
            if (32'(row_cnt) == DIM_Y - 1) begin
               state_nxt = IDLE;
               row_nxt   = '0;
            end else begin
               row_nxt = row_cnt + RW'(1);
            end
         end
         SWAP_PEND: begin
            if (frame_tick) begin
               commit = 1'b1;
`ifdef FB_AUTO_CLEAR_EN
               state_nxt = CLEAR;
               row_nxt   = '0;
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         row_cnt   <= '0;
         front_sel <= 1'b0;
         buf0      <= '0;
         buf1      <= '0;
         img       <= '0;
         oob       <= 1'b0;
      end else begin
         state   <= state_nxt;
         row_cnt <= row_nxt;
         if (commit) front_sel <= ~front_sel;
         if (front_sel) buf0 <= back_nxt;
         else           buf1 <= back_nxt;
         // Load the committing buffer directly so img follows swap_ack by one cycle.
         img <= commit ? back : front;
         oob <= wr_fire & ~in_range;
      end
   end
endmodule
